ram_reader32: RTL and testbench

RAM_READER32 -- requirements
Module: ram_reader32

---
 rtl/ram_reader32.sv | 85 ++++++++
 tb/tb_ram_reader32.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_reader32.sv
// Read side of a 32x16 RAM FIFO: drains words into a registered DO/VLD stage.
// Ports: CLK, RST, WPTR, RDATA in; RADDR, RPTR, DO, VLD, LEVEL, EMPTY, ERR out; RDY, FLUSH in.
module ram_reader32 (
  input  logic        CLK,
  input  logic        RST,
  input  logic [5:0]  WPTR,
  input  logic [15:0] RDATA,
  output logic [4:0]  RADDR,
  output logic [5:0]  RPTR,
  output logic [15:0] DO,
  output logic        VLD,
  input  logic        RDY,
  input  logic        FLUSH,
  output logic [5:0]  LEVEL,
  output logic        EMPTY,
  output logic        ERR
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;
  logic [5:0]  r_rptr;
  logic [5:0]  w_rptr_nx;
  logic [15:0] r_do;
  logic [15:0] w_do_nx;
  logic        r_err;
  logic        w_err_nx;

  logic [5:0]  w_level;
  logic        w_empty;
  logic        w_err_now;
  logic        w_ld;

  // 6-bit modulo distance; the wrap bit makes 32 (full) distinct from 0.
  assign w_level   = WPTR - r_rptr;
  assign w_empty   = (w_level == 6'd0);
  // More than 32 outstanding words cannot happen with sane pointers.
  assign w_err_now = (w_level > 6'd32);
  assign w_ld      = !w_empty && !w_err_now &&
                     ((r_state == S_IDLE) || RDY);

  always_comb begin
    w_state_nx = r_state;
    w_rptr_nx  = r_rptr;
    w_do_nx    = r_do;
    w_err_nx   = r_err | w_err_now;
    if (FLUSH) begin
      w_rptr_nx  = WPTR;
      w_state_nx = S_IDLE;
    end else if (w_ld) begin
      w_do_nx    = RDATA;
      w_rptr_nx  = r_rptr + 6'd1;
      w_state_nx = S_HOLD;
    end else if (r_state == S_HOLD && RDY) begin
      w_state_nx = S_IDLE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_rptr  <= 6'd0;
      r_do    <= 16'h0000;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_rptr  <= w_rptr_nx;
      r_do    <= w_do_nx;
      r_err   <= w_err_nx;
    end
  end

  assign RADDR = r_rptr[4:0];
  assign RPTR  = r_rptr;
  assign DO    = r_do;
  assign VLD   = (r_state == S_HOLD);
  assign LEVEL = w_level;
  assign EMPTY = w_empty;
  assign ERR   = r_err;

endmodule

// File: tb/tb_ram_reader32.sv
// Directed self-checking bench for ram_reader32 with a behavioural RAM.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ram_reader32;

  logic        CLK;
  logic        RST;
  logic [5:0]  WPTR;
  logic [15:0] RDATA;
  logic [4:0]  RADDR;
  logic [5:0]  RPTR;
  logic [15:0] DO;
  logic        VLD;
  logic        RDY;
  logic        FLUSH;
  logic [5:0]  LEVEL;
  logic        EMPTY;
  logic        ERR;

  logic [15:0] ram [32];
  int n_tests;
  int n_fail;

  assign RDATA = ram[RADDR];

  ram_reader32 dut (
    .CLK(CLK), .RST(RST), .WPTR(WPTR), .RDATA(RDATA),
    .RADDR(RADDR), .RPTR(RPTR), .DO(DO), .VLD(VLD),
    .RDY(RDY), .FLUSH(FLUSH), .LEVEL(LEVEL),
    .EMPTY(EMPTY), .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1; WPTR = 6'd0; RDY = 1'b0; FLUSH = 1'b0;
    tick();
    n_tests++;
    if ({VLD, EMPTY, LEVEL, RPTR, DO} !== {1'b0, 1'b1, 6'd0, 6'd0, 16'h0}) begin
      n_fail++;
      $display("FAIL reset: vld=%b empty=%b level=%0d rptr=%0d do=%h want 0 1 0 0 0000",
               VLD, EMPTY, LEVEL, RPTR, DO);
    end
    n_tests++;
    if (ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_err: got %b want 0", ERR);
    end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_stream();
    logic [15:0] exp [3];
    exp[0] = 16'hA1A1; exp[1] = 16'hA2A2; exp[2] = 16'hA3A3;
    for (int i = 0; i < 3; i++) ram[i] = exp[i];
    RDY = 1'b1;
    WPTR = 6'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (VLD !== 1'b1 || DO !== exp[i]) begin
        n_fail++;
        $display("FAIL stream_word%0d: vld=%b do=%h want 1 %h", i, VLD, DO, exp[i]);
      end
    end
    tick();
    n_tests++;
    if (VLD !== 1'b0 || RPTR !== 6'd3) begin
      n_fail++;
      $display("FAIL stream_end: vld=%b rptr=%0d want 0 3", VLD, RPTR);
    end
  endtask

  task automatic test_full();
    RST = 1'b1; WPTR = 6'd0; RDY = 1'b0;
    tick();
    RST = 1'b0;
    for (int i = 0; i < 32; i++) ram[i] = 16'h1000 + 16'(i);
    WPTR = 6'd32;
    #1;
    n_tests++;
    if (LEVEL !== 6'd32 || EMPTY !== 1'b0) begin
      n_fail++;
      $display("FAIL full_level: level=%0d empty=%b want 32 0", LEVEL, EMPTY);
    end
    tick();
    n_tests++;
    if (VLD !== 1'b1 || DO !== 16'h1000 || LEVEL !== 6'd31 || RPTR !== 6'd1) begin
      n_fail++;
      $display("FAIL full_first: vld=%b do=%h level=%0d rptr=%0d want 1 1000 31 1",
               VLD, DO, LEVEL, RPTR);
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      n_tests++;
      if (VLD !== 1'b1 || DO !== 16'h1000 || RPTR !== 6'd1) begin
        n_fail++;
        $display("FAIL full_hold%0d: vld=%b do=%h rptr=%0d want 1 1000 1",
                 c, VLD, DO, RPTR);
      end
    end
    RDY = 1'b1;
    for (int i = 1; i < 32; i++) begin
      tick();
      n_tests++;
      if (VLD !== 1'b1 || DO !== 16'h1000 + 16'(i)) begin
        n_fail++;
        $display("FAIL full_word%0d: vld=%b do=%h want 1 %h",
                 i, VLD, DO, 16'h1000 + 16'(i));
      end
    end
    n_tests++;
    if (RPTR !== 6'd32 || RADDR !== 5'd0 || LEVEL !== 6'd0) begin
      n_fail++;
      $display("FAIL full_wrap: rptr=%0d raddr=%0d level=%0d want 32 0 0",
               RPTR, RADDR, LEVEL);
    end
    tick();
    n_tests++;
    if (VLD !== 1'b0 || RPTR !== 6'd32) begin
      n_fail++;
      $display("FAIL full_drain: vld=%b rptr=%0d want 0 32", VLD, RPTR);
    end
  endtask

  task automatic test_wrap();
    logic [4:0]  addr [4];
    addr[0] = 5'd30; addr[1] = 5'd31; addr[2] = 5'd0; addr[3] = 5'd1;
    FLUSH = 1'b1; WPTR = 6'd62;
    tick();
    FLUSH = 1'b0;
    n_tests++;
    if (RPTR !== 6'd62 || VLD !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_setup: rptr=%0d vld=%b want 62 0", RPTR, VLD);
    end
    for (int i = 0; i < 4; i++) ram[addr[i]] = 16'hB000 + 16'(i);
    WPTR = 6'd2; RDY = 1'b1;
    #1;
    n_tests++;
    if (LEVEL !== 6'd4 || RADDR !== 5'd30) begin
      n_fail++;
      $display("FAIL wrap_level: level=%0d raddr=%0d want 4 30", LEVEL, RADDR);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if (VLD !== 1'b1 || DO !== 16'hB000 + 16'(i)) begin
        n_fail++;
        $display("FAIL wrap_word%0d: vld=%b do=%h want 1 %h",
                 i, VLD, DO, 16'hB000 + 16'(i));
      end
    end
    tick();
    n_tests++;
    if (VLD !== 1'b0 || RPTR !== 6'd2) begin
      n_fail++;
      $display("FAIL wrap_end: vld=%b rptr=%0d want 0 2", VLD, RPTR);
    end
  endtask

  task automatic test_flush();
    RDY = 1'b0;
    for (int i = 2; i < 8; i++) ram[i] = 16'hC000 + 16'(i);
    WPTR = 6'd8;
    tick();
    n_tests++;
    if (VLD !== 1'b1 || DO !== 16'hC002 || LEVEL !== 6'd5) begin
      n_fail++;
      $display("FAIL flush_pre: vld=%b do=%h level=%0d want 1 c002 5", VLD, DO, LEVEL);
    end
    FLUSH = 1'b1; RDY = 1'b1;
    tick();
    FLUSH = 1'b0; RDY = 1'b0;
    n_tests++;
    if (VLD !== 1'b0 || RPTR !== 6'd8 || LEVEL !== 6'd0 || EMPTY !== 1'b1) begin
      n_fail++;
      $display("FAIL flush: vld=%b rptr=%0d level=%0d empty=%b want 0 8 0 1",
               VLD, RPTR, LEVEL, EMPTY);
    end
  endtask

  task automatic test_err();
    WPTR = 6'd48; RDY = 1'b1;
    tick();
    n_tests++;
    if (ERR !== 1'b1 || VLD !== 1'b0 || RPTR !== 6'd8) begin
      n_fail++;
      $display("FAIL err_set: err=%b vld=%b rptr=%0d want 1 0 8", ERR, VLD, RPTR);
    end
    tick();
    tick();
    n_tests++;
    if (ERR !== 1'b1 || VLD !== 1'b0 || RPTR !== 6'd8) begin
      n_fail++;
      $display("FAIL err_noload: err=%b vld=%b rptr=%0d want 1 0 8", ERR, VLD, RPTR);
    end
    RST = 1'b1; WPTR = 6'd0;
    tick();
    RST = 1'b0;
    n_tests++;
    if (ERR !== 1'b0 || RPTR !== 6'd0) begin
      n_fail++;
      $display("FAIL err_clear: err=%b rptr=%0d want 0 0", ERR, RPTR);
    end
  endtask

  task automatic test_reset_mid();
    RDY = 1'b0;
    ram[0] = 16'hD00D; ram[1] = 16'hD11D;
    WPTR = 6'd2;
    tick();
    n_tests++;
    if (VLD !== 1'b1 || DO !== 16'hD00D) begin
      n_fail++;
      $display("FAIL mid_load: vld=%b do=%h want 1 d00d", VLD, DO);
    end
    RST = 1'b1; RDY = 1'b1; FLUSH = 1'b1;
    tick();
    n_tests++;
    if (VLD !== 1'b0 || DO !== 16'h0 || RPTR !== 6'd0 || LEVEL !== 6'd2) begin
      n_fail++;
      $display("FAIL mid_reset: vld=%b do=%h rptr=%0d level=%0d want 0 0000 0 2",
               VLD, DO, RPTR, LEVEL);
    end
    RST = 1'b0; FLUSH = 1'b0; RDY = 1'b0;
    tick();
    n_tests++;
    if (VLD !== 1'b1 || DO !== 16'hD00D || RPTR !== 6'd1) begin
      n_fail++;
      $display("FAIL mid_reload: vld=%b do=%h rptr=%0d want 1 d00d 1", VLD, DO, RPTR);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    RST = 1'b1; WPTR = 6'd0; RDY = 1'b0; FLUSH = 1'b0;
    for (int i = 0; i < 32; i++) ram[i] = 16'h0;
    @(negedge CLK);
    test_reset();
    test_stream();
    test_full();
    test_wrap();
    test_flush();
    test_err();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
